mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one port (A or B) of the single-clock true dual-port RAM between two requesters.
//  Arbitrates round-robin per cycle and supports a lock for atomic read-modify-write sequences.
//  Routes the RAM's 1-cycle read data back to the requester that issued the read.
//  Sits between two masters (e.g. CPU load/store unit and DMA) and one RAM port.
// PARAMETERS
//  DATA_WIDTH  32  data width; must match the RAM instance
//  ADDR_WIDTH  12  address width; must match the RAM instance
//  MAX_LOCK    4   max consecutive granted cycles one requester may hold via lock (>=2)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  reqN_valid   in   1      (N=0,1) requester N presents a transfer
//  reqN_we      in   1      1 = write, 0 = read
//  reqN_lock    in   1      keep ownership after this transfer (RMW)
//  reqN_addr    in   AW     word address
//  reqN_wdata   in   DW     write data
//  reqN_ready   out  1      combinational grant: transfer accepted this cycle
//  rspN_valid   out  1      read data valid for requester N (registered)
//  rspN_rdata   out  DW     read data; equals mem_q while rspN_valid=1
//  mem_addr     out  AW     to RAM addr_x
//  mem_data     out  DW     to RAM data_x
//  mem_we       out  1      to RAM we_x
//  mem_q        in   DW     from RAM q_x
// BEHAVIOUR
//  - Transfer completes on a rising edge where reqN_valid && reqN_ready. At most one grant per cycle.
//  - The RAM port is driven combinationally from the granted request.
//  - With no grant: mem_we=0, mem_addr=0, mem_data=0.
//  - Arbitration when unlocked:
//      only one requester valid -> that requester is granted;
//      both valid -> grant goes to the one NOT granted last (last_grant register).
//  - last_grant resets to 1, so requester 0 wins the first tie after reset.
//  - FSM states: IDLE, OWN0, OWN1.
//      IDLE: arbitrate as above. Grant to N with reqN_lock=1 -> OWNN, lock_cnt=1.
//      OWNN: only N may be granted; the other requester's ready=0 even if N is idle.
//        N granted with lock=1 and lock_cnt<MAX_LOCK-1 -> stay in OWNN, lock_cnt++.
//        N granted with lock=0 -> IDLE.
//        N granted with lock_cnt==MAX_LOCK-1 -> IDLE regardless of lock (forced release).
//        On a forced release, last_grant=N, so the other requester wins the next tie.
//        N not valid for a cycle -> stay in OWNN; lock_cnt does not advance.
//  - Read latency: read granted at edge k -> rspN_valid=1 in cycle k+1 with rspN_rdata=mem_q.
//  - rspN_valid is a 1-cycle pulse per read and cannot be back-pressured.
//  - Back-to-back reads give back-to-back responses.
//  - Writes produce no response.
//  - rsp_sel/rsp_pend registers record which requester the in-flight read belongs to.
//  - rspN_rdata=0 when rspN_valid=0.
//  - Write then read of the same address in consecutive cycles returns the new data (RAM semantics).
//  - Reset (async, rst_n=0): state=IDLE, lock_cnt=0, last_grant=1, all ready/rsp_valid=0,
//    mem_we=0, mem_addr/mem_data=0. An in-flight read response is dropped.
//    Reset mid-lock releases ownership.
//  - Contention from the other RAM port on the same address is outside this block's scope.
// TESTING
//  1. Only req0 reads addr 0x010 (RAM holds 0xDEADBEEF) -> ready0=1, mem_we=0;
//     next cycle rsp0_valid=1, rsp0_rdata=0xDEADBEEF; rsp1_valid=0.
//  2. Both valid every cycle, no lock, from reset -> grants alternate 0,1,0,1;
//     each read response lands on the matching rspN one cycle later.
//  3. req0 write 0x5 to 0x020 with lock=1, then read 0x020 with lock=0; req1 valid throughout
//     -> req1 ready=0 for both cycles, granted in the 3rd cycle.
//  4. MAX_LOCK=4, req0 holds lock=1 on every transfer with req1 valid
//     -> req0 gets exactly 4 grants, then req1 is granted.
//  5. req1 read granted, rst_n pulled low before the next edge
//     -> rsp1_valid stays 0, all outputs 0, FSM=IDLE; after release req0 wins the first tie.
//  6. req1 in OWN1 drops valid for 2 cycles while req0 is valid
//     -> ready0=0 throughout; lock_cnt unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one port of a single-clock true dual-port RAM.
// Round-robin per cycle, bounded lock for RMW sequences, 1-cycle read data routing.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned MAX_LOCK   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic                  req0_lock,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,

  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic                  req1_lock,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,

  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam int unsigned CntW = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_LOCK - 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
  logic            last_grant_q, last_grant_d;
  logic            rsp_pend_q, rsp_pend_d;
  logic            rsp_sel_q, rsp_sel_d;
  logic            gnt0, gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      lock_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      rsp_pend_q   <= 1'b0;
      rsp_sel_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      last_grant_q <= last_grant_d;
      rsp_pend_q   <= rsp_pend_d;
      rsp_sel_q    <= rsp_sel_d;
    end
  end

  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (req0_valid && req1_valid) begin
          gnt0 = last_grant_q;
          gnt1 = !last_grant_q;
        end else begin
          gnt0 = req0_valid;
          gnt1 = req1_valid;
        end
        if (gnt0 && req0_lock) begin
          state_d    = StOwn0;
          lock_cnt_d = CntW'(1);
        end else if (gnt1 && req1_lock) begin
          state_d    = StOwn1;
          lock_cnt_d = CntW'(1);
        end
      end
      StOwn0: begin
        gnt0 = req0_valid;
        if (gnt0) begin
          // The last permitted grant releases ownership even with lock still set.
          if (!req0_lock || lock_cnt_q == CntLast) begin
            state_d    = StIdle;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + CntW'(1);
          end
        end
      end
      StOwn1: begin
        gnt1 = req1_valid;
        if (gnt1) begin
          if (!req1_lock || lock_cnt_q == CntLast) begin
            state_d    = StIdle;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d    = StIdle;
        lock_cnt_d = '0;
      end
    endcase

    // Grants are combinational, so hold them off while reset is asserted.
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    last_grant_d = last_grant_q;
    if (gnt0) begin
      last_grant_d = 1'b0;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
    end

    rsp_pend_d = (gnt0 && !req0_we) || (gnt1 && !req1_we);
    rsp_sel_d  = gnt1;
  end

  always_comb begin
    req0_ready = gnt0;
    req1_ready = gnt1;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;
    if (gnt0) begin
      mem_we   = req0_we;
      mem_addr = req0_addr;
      mem_data = req0_wdata;
    end else if (gnt1) begin
      mem_we   = req1_we;
      mem_addr = req1_addr;
      mem_data = req1_wdata;
    end

    rsp0_valid = rsp_pend_q && !rsp_sel_q;
    rsp1_valid = rsp_pend_q && rsp_sel_q;
    rsp0_rdata = rsp0_valid ? mem_q : '0;
    rsp1_rdata = rsp1_valid ? mem_q : '0;
  end

endmodule
